divider4: RTL and testbench

Sequential signed integer divider, the inverse companion to the team's sequential shift-add multiplier. Accepts an nb-bit dividend and divisor on a one-cycle `start` pulse, runs one restoring-division step per clock on operand magnitudes, applies sign correction, and presents Quotient/Remainder with `ready`. It shares the multiplier's start/ready handshake and fixed-latency contract, so the same benches and sequencers drive both units.

---
 rtl/divider_pkg.sv | 19 +
 rtl/divider4_if.sv | 49 ++++
 rtl/div_step.sv | 30 +++
 rtl/divider4.sv | 148 ++++++++++++++
 tb/tb_divider4.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the divider4 sequential divider.
//   state_e    - FSM state encoding (idle / iterate / sign fix-up)
//   NB_DEFAULT - default operand width
//   cnt_width  - width of the iteration counter for a given operand width
package divider_pkg;

    localparam int unsigned NB_DEFAULT = 50;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider4_if.sv
// divider4_if: start/ready handshake bundle for the divider.
//   start     - one-cycle request, operands sampled on the same edge
//   A, B      - signed dividend / divisor
//   Quotient  - signed quotient, truncated toward zero
//   Remainder - signed remainder, sign follows the dividend
//   ready     - idle, outputs valid
//   div_by_zero (only with DIVIDER_DZ_DETECT_EN) - last accepted divisor was zero
// Modports: master drives requests, slave is the divider.
interface divider4_if
    import divider_pkg::*;
#(
    parameter int unsigned nb = NB_DEFAULT
);

    logic          start;
    logic [nb-1:0] A;
    logic [nb-1:0] B;
    logic [nb-1:0] Quotient;
    logic [nb-1:0] Remainder;
    logic          ready;
`ifdef DIVIDER_DZ_DETECT_EN
    logic          div_by_zero;
`endif

    modport master (
        output start,
        output A,
        output B,
        input  Quotient,
        input  Remainder,
`ifdef DIVIDER_DZ_DETECT_EN
        input  div_by_zero,
`endif
        input  ready
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output Quotient,
        output Remainder,
`ifdef DIVIDER_DZ_DETECT_EN
        output div_by_zero,
`endif
        output ready
    );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
//   rem_in  - partial remainder before the step (nb+1 bits)
//   dvd_bit - next dividend bit shifted in at the LSB
//   dsr     - divisor magnitude
//   rem_out - partial remainder after the step
//   q_bit   - quotient bit produced by the step
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned nb = NB_DEFAULT
) (
    input  logic [nb:0]   rem_in,
    input  logic          dvd_bit,
    input  logic [nb-1:0] dsr,
    output logic [nb:0]   rem_out,
    output logic          q_bit
);

    // One extra bit above the shifted remainder carries the trial sign.
    logic [nb+1:0] shifted;
    logic [nb+1:0] trial;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {2'b00, dsr};
        q_bit   = ~trial[nb+1];
        rem_out = q_bit ? trial[nb:0] : shifted[nb:0];
    end

endmodule

// File: rtl/divider4.sv
// divider4: sequential signed divider, one restoring step per clock.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - divider4_if slave (start, A, B, Quotient, Remainder, ready)
// Latency is nb+1 cycles from the accepting edge to ready.
// Build option: DIVIDER_DZ_DETECT_EN adds div_by_zero and a one-cycle
// short path for a zero divisor; without it a zero divisor runs the full
// iteration and yields Quotient = -1 (A >= 0) or +1 (A < 0), Remainder = A.
module divider4
    import divider_pkg::*;
#(
    parameter int unsigned nb = NB_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    divider4_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(nb);

    state_e state_q, state_d;

    logic [nb:0]     rem_q;     // partial remainder
    logic [nb-1:0]   dvd_q;     // dividend magnitude, quotient bits shift in from the LSB
    logic [nb-1:0]   dsr_q;     // divisor magnitude
    logic [CntW-1:0] cnt_q;
    logic            sign_q_q;  // quotient negative
    logic            sign_r_q;  // remainder negative
    logic [nb-1:0]   quot_q;
    logic [nb-1:0]   rmd_q;

    logic            accept;
    logic            last_step;
    logic            dz_skip;
    logic [nb-1:0]   a_mag;
    logic [nb-1:0]   b_mag;
    logic [nb:0]     step_rem;
    logic            step_q;
    logic [nb-1:0]   q_mag;
    logic [nb-1:0]   r_mag;

    assign accept    = (state_q == StIdle) && bus.start;
    assign last_step = (cnt_q == CntW'(nb - 1));

    // nb-bit magnitudes: |-2^(nb-1)| wraps to 2^(nb-1), which is exact unsigned.
    assign a_mag = bus.A[nb-1] ? ('0 - bus.A) : bus.A;
    assign b_mag = bus.B[nb-1] ? ('0 - bus.B) : bus.B;

`ifdef DIVIDER_DZ_DETECT_EN
    logic dz_q;
    assign dz_skip = (bus.B == '0);
`else
    assign dz_skip = 1'b0;
`endif

    div_step #(
        .nb (nb)
    ) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[nb-1]),
        .dsr     (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = dz_skip ? StFix : StCalc;
            StCalc: if (last_step) state_d = StFix;
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Magnitudes fed to the sign fix-up
    always_comb begin
        q_mag = dvd_q;
        r_mag = rem_q[nb-1:0];
`ifdef DIVIDER_DZ_DETECT_EN
        // CALC was skipped, so dvd_q still holds |A|.
        if (dz_q) begin
            q_mag = '0;
            r_mag = dvd_q;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            quot_q   <= '0;
            rmd_q    <= '0;
        end else if (accept) begin
            rem_q    <= '0;
            dvd_q    <= a_mag;
            dsr_q    <= b_mag;
            cnt_q    <= '0;
            sign_q_q <= bus.A[nb-1] ^ bus.B[nb-1];
            sign_r_q <= bus.A[nb-1];
        end else if (state_q == StCalc) begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[nb-2:0], step_q};
            cnt_q <= cnt_q + CntW'(1);
        end else if (state_q == StFix) begin
            quot_q <= sign_q_q ? ('0 - q_mag) : q_mag;
            rmd_q  <= sign_r_q ? ('0 - r_mag) : r_mag;
        end
    end

`ifdef DIVIDER_DZ_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else if (accept) begin
            dz_q <= dz_skip;
        end
    end
`endif

    // Outputs
    always_comb begin
        bus.ready     = (state_q == StIdle);
        bus.Quotient  = quot_q;
        bus.Remainder = rmd_q;
`ifdef DIVIDER_DZ_DETECT_EN
        bus.div_by_zero = dz_q;
`endif
    end

endmodule

// File: tb/tb_divider4.sv
// tb_divider4: directed checks on an nb=8 divider plus back-to-back random
// operands on an nb=50 divider compared against a signed integer model.
module tb_divider4;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    divider4_if #(.nb(8))  if8  ();
    divider4_if #(.nb(50)) if50 ();

    divider4 #(.nb(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    divider4 #(.nb(50)) dut50 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if50)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns on the negedge after the accepting edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.A     = a;
        if8.B     = b;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    // Count edges until ready, bounded.
    task automatic wait8(output int lat);
        lat = 0;
        while (!if8.ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int exp_lat, input logic [7:0] exp_q, input logic [7:0] exp_r);
        int lat;
        start8(a, b);
        check({tag, " busy"}, 64'(if8.ready), 64'd0);
        wait8(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " quotient"}, 64'(if8.Quotient), 64'(exp_q));
        check({tag, " remainder"}, 64'(if8.Remainder), 64'(exp_r));
    endtask

    initial begin
        int lat;
        logic [63:0] ra, rb;
        logic [49:0] a50, b50;
        longint a_s, b_s, q_s, r_s;

        rst_n      = 1'b0;
        if8.start  = 1'b0;
        if8.A      = '0;
        if8.B      = '0;
        if50.start = 1'b0;
        if50.A     = '0;
        if50.B     = '0;

        #12;
        check("reset ready", 64'(if8.ready), 64'd1);
        check("reset quotient", 64'(if8.Quotient), 64'd0);
        check("reset remainder", 64'(if8.Remainder), 64'd0);
        check("reset ready nb50", 64'(if50.ready), 64'd1);
`ifdef DIVIDER_DZ_DETECT_EN
        check("reset div_by_zero", 64'(if8.div_by_zero), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        op8("100/7", 8'd100, 8'd7, 9, 8'd14, 8'd2);
        op8("-100/7", 8'h9C, 8'd7, 9, 8'hF2, 8'hFE);
        op8("100/-7", 8'd100, 8'hF9, 9, 8'hF2, 8'd2);
        op8("-128/-1", 8'h80, 8'hFF, 9, 8'h80, 8'd0);
        op8("-128/1", 8'h80, 8'd1, 9, 8'h80, 8'd0);
        op8("-7/-100", 8'hF9, 8'h9C, 9, 8'd0, 8'hF9);
`ifdef DIVIDER_DZ_DETECT_EN
        op8("5/0", 8'd5, 8'd0, 1, 8'd0, 8'd5);
        check("5/0 div_by_zero", 64'(if8.div_by_zero), 64'd1);
        op8("9/2", 8'd9, 8'd2, 9, 8'd4, 8'd1);
        check("9/2 div_by_zero clear", 64'(if8.div_by_zero), 64'd0);
`else
        op8("5/0", 8'd5, 8'd0, 9, 8'hFF, 8'd5);
        op8("-5/0", 8'hFB, 8'd0, 9, 8'd1, 8'hFB);
`endif

        // Second start during CALC must be ignored.
        start8(8'd100, 8'd7);
        @(negedge clk);
        if8.A     = 8'd1;
        if8.B     = 8'd1;
        if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        wait8(lat);
        check("ignored start ready", 64'(if8.ready), 64'd1);
        check("ignored start quotient", 64'(if8.Quotient), 64'd14);
        check("ignored start remainder", 64'(if8.Remainder), 64'd2);
        @(negedge clk);
        check("ignored start not queued", 64'(if8.ready), 64'd1);

        // Reset mid-operation aborts and clears the last result.
        start8(8'd50, 8'd3);
        repeat (3) @(negedge clk);
        check("abort busy", 64'(if8.ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort ready", 64'(if8.ready), 64'd1);
        check("abort quotient", 64'(if8.Quotient), 64'd0);
        check("abort remainder", 64'(if8.Remainder), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // nb=50 back-to-back: next start issued on the cycle ready is seen.
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            a50 = 50'(ra >> $urandom_range(14, 40));
            b50 = 50'(rb >> $urandom_range(14, 60));
            if ($urandom_range(0, 1) == 1) a50 = '0 - a50;
            if ($urandom_range(0, 1) == 1) b50 = '0 - b50;
            if (b50 == '0) b50 = 50'd3;
            if (i == 0) begin
                a50 = 50'h2_0000_0000_0000;
                b50 = 50'h3_FFFF_FFFF_FFFF;
            end
            a_s = longint'($signed(a50));
            b_s = longint'($signed(b50));
            q_s = a_s / b_s;
            r_s = a_s % b_s;
            if50.A     = a50;
            if50.B     = b50;
            if50.start = 1'b1;
            @(negedge clk);
            if50.start = 1'b0;
            lat = 0;
            while (!if50.ready && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("nb50 #%0d latency", i), 64'(lat), 64'd51);
            check($sformatf("nb50 #%0d quotient", i), 64'(if50.Quotient), 64'(q_s[49:0]));
            check($sformatf("nb50 #%0d remainder", i), 64'(if50.Remainder), 64'(r_s[49:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
